// File: rtl/fifo_umbral_if.sv
// fifo_umbral_if: handshake/data bundle between a lane FIFO, its producer
// (lane arbiter) and its consumer.
//   push, fifo_in        producer -> FIFO write request and data
//   pop                  consumer -> FIFO read request
//   fifo_out, valid_out  FIFO -> consumer registered read data and strobe
//   empty, full,
//   almost_full,
//   almost_empty         FIFO status flags (decoded from occupancy)
//   error                sticky overflow/underflow flag, only when the
//                        FIFO_ERR_EN macro is defined
// Modports: master = producer/consumer side, slave = FIFO side.
interface fifo_umbral_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  push;
  logic [DATA_WIDTH-1:0] fifo_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
`ifdef FIFO_ERR_EN
  logic                  error;

  modport master (
    output push, fifo_in, pop,
    input  fifo_out, valid_out, empty, full, almost_full, almost_empty, error
  );
  modport slave (
    input  push, fifo_in, pop,
    output fifo_out, valid_out, empty, full, almost_full, almost_empty, error
  );
`else
  modport master (
    output push, fifo_in, pop,
    input  fifo_out, valid_out, empty, full, almost_full, almost_empty
  );
  modport slave (
    input  push, fifo_in, pop,
    output fifo_out, valid_out, empty, full, almost_full, almost_empty
  );
`endif
endinterface

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full/almost-empty
// thresholds and a registered read port (one cycle read latency).
// Ports:
//   clk    single clock, all state updates on its rising edge
//   reset  synchronous, active-high; clears pointers, count, read port, error
//   bus    fifo_umbral_if.slave (push/fifo_in, pop, fifo_out/valid_out, flags)
// Optional feature: define FIFO_ERR_EN to add the sticky bus.error flag
// (set by a push rejected while full without pop, or a pop while empty).
module fifo_umbral #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input logic          clk,
  input logic          reset,
  fifo_umbral_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_out_q, fifo_out_d;
  logic                  valid_q, valid_d;

  logic full, empty;
  logic push_ok, pop_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A pop in the same cycle frees a slot, so a push to a full FIFO is legal then.
  assign push_ok = bus.push & (~full | bus.pop);
  assign pop_ok  = bus.pop & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fifo_out_d = fifo_out_q;
    valid_d    = 1'b0;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      fifo_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_out_q <= fifo_out_d;
      valid_q    <= valid_d;
    end
  end

  // Storage is deliberately not cleared by reset; writes are only blocked.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= bus.fifo_in;
  end

  assign bus.fifo_out     = fifo_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);

`ifdef FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (bus.push & full & ~bus.pop) | (bus.pop & empty);
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.error = err_q;
`endif

endmodule

// File: tb/tb_fifo_umbral.sv
module tb_fifo_umbral;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_umbral_if #(.DATA_WIDTH(DW)) bus ();

  fifo_umbral #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(3),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  // Reference model: a queue of stored words plus the read-port registers.
  int        q[$];
  logic [DW-1:0] m_out   = '0;
  logic          m_valid = 1'b0;
  logic          m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic p, input logic [DW-1:0] d, input logic po);
    bit was_full, was_empty, acc_push, acc_pop;
    if (r) begin
      q.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    acc_pop   = po && !was_empty;
    acc_push  = p && (!was_full || po);
    if ((p && was_full && !po) || (po && was_empty)) m_err = 1'b1;
    if (acc_pop) begin
      m_out   = DW'(q.pop_front());
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (acc_push) q.push_back(int'(d));
  endtask

  // Drive one cycle of inputs, advance past the edge, then compare everything.
  task automatic step(input logic r, input logic p, input logic [DW-1:0] d, input logic po);
    reset       = r;
    bus.push    = p;
    bus.fifo_in = d;
    bus.pop     = po;
    @(posedge clk);
    model_edge(r, p, d, po);
    #1;
    chk("fifo_out",     32'(bus.fifo_out),     32'(m_out));
    chk("valid_out",    32'(bus.valid_out),    32'(m_valid));
    chk("empty",        32'(bus.empty),        32'(q.size() == 0));
    chk("full",         32'(bus.full),         32'(q.size() == DEPTH));
    chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
`ifdef FIFO_ERR_EN
    chk("error",        32'(bus.error),        32'(m_err));
`endif
  endtask

  initial begin
    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.fifo_in = '0;

    // Reset state.
    step(1, 0, '0, 0);
    step(1, 1, 12'h555, 1);

    // Fill with 0x100..0x107.
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(12'h100 + i), 0);
    chk("full_after_fill", 32'(bus.full), 32'd1);

    // Push+pop while full: 0x2AA takes the freed slot, reads out ninth.
    step(0, 1, 12'h2AA, 1);
    chk("first_word", 32'(bus.fifo_out), 32'h100);
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1);
    chk("ninth_word", 32'(bus.fifo_out), 32'h2AA);
    step(0, 0, '0, 0);

    // Refill, then overflow push of 0x3FF is dropped.
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(12'h100 + i), 0);
    step(0, 1, 12'h3FF, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, '0, 1);
    step(1, 0, '0, 0);

    // Wrap test at occupancy 3.
    for (int i = 0; i < 3; i++) step(0, 1, DW'(12'h200 + i), 0);
    for (int i = 0; i < 20; i++) step(0, 1, DW'($urandom_range(0, 4095)), 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);

    // Reset mid-operation with words stored and pop high.
    for (int i = 0; i < 5; i++) step(0, 1, DW'(12'h300 + i), 0);
    step(1, 0, '0, 1);
    step(0, 0, '0, 1);
    // Pop on empty with push: push still accepted.
    step(0, 1, 12'h0AB, 1);
    step(0, 0, '0, 1);

    // Randomized traffic with varying push/pop bias and rare resets.
    for (int blk = 0; blk < 4; blk++) begin
      int unsigned pp, pq;
      pp = 30 + 15 * blk;
      pq = 75 - 15 * blk;
      for (int i = 0; i < 120; i++) begin
        step(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 99) < pp),
             DW'($urandom_range(0, 4095)),
             ($urandom_range(0, 99) < pq));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
